xgriscv_dmem_lat: RTL and testbench

Parametrised, multi-cycle data memory for the pipelined xg-riscv core. It replaces the single-cycle data memory with three additions: a request/response handshake, a configurable access latency, and in-memory handling of access size. It performs byte/half/word lane steering and load sign/zero extension, and reports misaligned or out-of-range accesses. It sits between the core's MEM stage and the storage array; the core stalls on `req_ready`/`rsp_valid`.

---
 rtl/xgriscv_dmem_lat.sv | 155 +++++++++++++++
 tb/tb_xgriscv_dmem_lat.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_dmem_lat.sv
// Multi-cycle data memory for the xg-riscv MEM stage: valid/ready request, fixed-latency
// response strobe, byte/half/word lane steering, load extension and access error reporting.
module xgriscv_dmem_lat #(
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] rsp_pc
);

  localparam int unsigned AddrW   = $clog2(WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q;

  logic [31:0] mem [WORDS];

  logic             accept, commit, from_req;
  logic             c_we, c_uns, err, oor;
  logic [1:0]       c_size;
  logic [31:0]      c_addr, c_wdata, c_pc;
  logic [AddrW-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wlane, word, shifted, ext, rdata_d;

  assign req_ready = (state_q != StWait);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (state_q == StWait) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = StResp;
        commit  = 1'b1;
      end
    end else if (accept) begin
      cnt_d = CntInit;
      if (CntInit == 4'd0) begin
        state_d = StResp;
        commit  = 1'b1;
      end else begin
        state_d = StWait;
      end
    end else begin
      state_d = StIdle;
    end
  end

  // A commit outside WAIT can only be a single-cycle access, so it uses the live request.
  assign from_req = (state_q != StWait);
  assign c_we     = from_req ? req_we       : we_q;
  assign c_uns    = from_req ? req_unsigned : uns_q;
  assign c_size   = from_req ? req_size     : size_q;
  assign c_addr   = from_req ? req_addr     : addr_q;
  assign c_wdata  = from_req ? req_wdata    : wdata_q;
  assign c_pc     = from_req ? req_pc       : pc_q;

  assign idx     = c_addr[2 +: AddrW];
  assign oor     = (c_addr >> (AddrW + 2)) != 32'd0;
  assign word    = mem[idx];
  assign shifted = word >> {c_addr[1:0], 3'b000};

  always_comb begin
    err   = oor;
    be    = 4'b0000;
    wlane = c_wdata;
    ext   = shifted;
    case (c_size)
      2'b00: begin
        be    = 4'b0001 << c_addr[1:0];
        wlane = {4{c_wdata[7:0]}};
        ext   = {{24{~c_uns & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be    = c_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{c_wdata[15:0]}};
        ext   = {{16{~c_uns & shifted[15]}}, shifted[15:0]};
        err   = oor | c_addr[0];
      end
      2'b10: begin
        be    = 4'b1111;
        ext   = word;
        err   = oor | (c_addr[1:0] != 2'b00);
      end
      default: err = 1'b1;
    endcase
    rdata_d = (c_we | err) ? 32'd0 : ext;
  end

  // Array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (commit && !reset && !err && c_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      pc_q      <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      rsp_pc    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= commit;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
      end
      if (commit) begin
        rsp_rdata <= rdata_d;
        rsp_err   <= err;
        rsp_pc    <= c_pc;
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_dmem_lat.sv
// Scoreboard bench: four DUTs (LATENCY 1..4) driven concurrently against a byte-array model.
module tb_xgriscv_dmem_lat;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] pc;
    logic [31:0] cyc;
  } exp_t;

  logic clk;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int lat, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL lat%0d %s actual=%h required=%h", lat, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int Lat = gi + 1;

    logic        reset, req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, rsp_pc;

    logic [7:0]  mdl [256];
    exp_t        exp_q [$];
    int          last_acc = -100;
    logic [31:0] pc_ctr   = 32'h1000 * (gi + 1);
    bit          done     = 1'b0;

    xgriscv_dmem_lat #(
      .WORDS    (64),
      .LATENCY  (Lat),
      .INIT_FILE("")
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_pc      (req_pc),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_pc      (rsp_pc)
    );

    // Reference: 256-byte little-endian array, sizes as byte counts.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
      int     n;
      longint v;
      rdata = 32'd0;
      if (size == 2'b11) begin
        err = 1'b1;
        return;
      end
      n   = 1 << size;
      err = (addr % n != 0) || (addr > 255);
      if (err) return;
      if (we) begin
        for (int k = 0; k < n; k++) mdl[addr + k] = wdata[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(mdl[addr + k]) << (8 * k);
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        rdata = v[31:0];
      end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
      int          n = 0;
      int          stall_exp;
      exp_t        e;
      logic [31:0] rd;
      logic        er;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_pc       = pc_ctr;
      pc_ctr       = pc_ctr + 32'd4;
      stall_exp    = last_acc + Lat - 1 - cyc;
      if (stall_exp < 0) stall_exp = 0;
      while (!req_ready) begin
        if (n >= 64) begin
          $display("FAIL lat%0d ready_timeout actual=stuck required=ready", Lat);
          $fatal(1);
        end
        @(negedge clk);
        n++;
      end
      chk(Lat, "stall_cycles", n, stall_exp);
      @(posedge clk);
      #1;
      last_acc = cyc;
      if (track) begin
        model(we, size, uns, addr, wdata, rd, er);
        e.rdata = rd;
        e.err   = er;
        e.pc    = req_pc;
        e.cyc   = cyc + Lat - 1;
        exp_q.push_back(e);
      end
    endtask

    task automatic drain();
      int n = 0;
      req_valid = 1'b0;
      while (exp_q.size() != 0 && n < Lat + 8) begin
        @(negedge clk);
        n++;
      end
      chk(Lat, "drain_empty", exp_q.size(), 0);
    endtask

    task automatic reset_outputs_chk();
      chk(Lat, "rst_req_ready", req_ready, 1);
      chk(Lat, "rst_rsp_valid", rsp_valid, 0);
      chk(Lat, "rst_rsp_rdata", rsp_rdata, 0);
      chk(Lat, "rst_rsp_err", rsp_err, 0);
      chk(Lat, "rst_rsp_pc", rsp_pc, 0);
    endtask

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL lat%0d unexpected_rsp actual=rsp_valid pc=%h required=no response",
                     Lat, rsp_pc);
          end else begin
            e = exp_q.pop_front();
            chk(Lat, "rsp_rdata", rsp_rdata, e.rdata);
            chk(Lat, "rsp_err", rsp_err, e.err);
            chk(Lat, "rsp_pc", rsp_pc, e.pc);
            chk(Lat, "rsp_cycle", cyc, e.cyc);
          end
        end
      end
    end

    initial begin : drv
      logic [1:0]  sz;
      logic [31:0] addr;
      int          r;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      req_pc       = 32'd0;
      repeat (2) @(negedge clk);
      reset_outputs_chk();
      reset = 1'b0;

      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
      for (int w = 0; w < 64; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), 32'd0, 1'b1);

      // Word round trip and sub-word lanes
      issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
      issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h5A5A5A80, 1'b1);
      issue(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 1'b1);
      issue(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 1'b1);
      issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
      // Errors must not disturb the array
      issue(1'b1, 2'b10, 1'b0, 32'h42, 32'h11111111, 1'b1);
      issue(1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 1'b1);
      issue(1'b1, 2'b01, 1'b0, 32'h41, 32'h2222, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h80000040, 32'h0, 1'b1);
      issue(1'b1, 2'b10, 1'b0, 32'h80000040, 32'h33333333, 1'b1);
      issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h44, 1'b1);
      issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1);
      issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h55, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
      // Back-to-back store/load pairs
      for (int i = 0; i < 8; i++) begin
        issue(1'b1, 2'b10, 1'b0, 32'(32'hC0 + 4 * i), $urandom, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'(32'hC0 + 4 * i), 32'h0, 1'b1);
      end
      drain();

      if (Lat >= 3) begin
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reset_outputs_chk();
        last_acc = -100;
      end
      // Request presented during reset must be ignored
      @(negedge clk);
      reset        = 1'b1;
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_addr     = 32'h80;
      req_wdata    = 32'hAAAAAAAA;
      @(negedge clk);
      reset        = 1'b0;
      req_valid    = 1'b0;
      reset_outputs_chk();
      last_acc = -100;
      repeat (Lat + 2) @(negedge clk);
      issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1);
      drain();

      for (int i = 0; i < 150; i++) begin
        r    = $urandom_range(0, 15);
        sz   = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
        addr = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
        else if (sz == 2'b00) addr = addr + 32'($urandom_range(0, 3));
        else if (sz == 2'b01) addr = addr + 32'(2 * $urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) addr = addr | (32'h100 << $urandom_range(0, 23));
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b1);
        if ($urandom_range(0, 7) == 0) begin
          drain();
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin : fin
    int n = 0;
    while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done)
           && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50000) begin
      checks++;
      failures++;
      $display("FAIL global_timeout actual=%0d cycles required=all streams done", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
